// File: rtl/io_scan_harness_if.sv
// Bus bundle for io_scan_harness: scan chain, apply/capture handshake,
// stimulus/response words and error status.
interface io_scan_harness_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int ERR_W = 8
);
  // Scan chain
  logic             scan_en;
  logic             scan_in;
  logic             scan_out;
  // Sequence control
  logic             apply;
  logic             clr_err;
  // DUT-facing words
  logic [IN_W-1:0]  stim_out;
  logic [OUT_W-1:0] resp_in;
  // Status
  logic             busy;
  logic             done;
  logic             fail;
  logic [ERR_W-1:0] err_cnt;

  // Controller side (test sequencer / bench)
  modport master (
    output scan_en, scan_in, apply, clr_err, resp_in,
    input  scan_out, stim_out, busy, done, fail, err_cnt
  );

  // Harness side
  modport slave (
    input  scan_en, scan_in, apply, clr_err, resp_in,
    output scan_out, stim_out, busy, done, fail, err_cnt
  );
endinterface

// File: rtl/io_scan_harness.sv
// io_scan_harness: scan-loaded stimulus/expected pair, applied to a DUT,
// held for a settle window, then the DUT response is captured, compared
// and shifted back out serially. Mismatches are counted (saturating).
module io_scan_harness #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  io_scan_harness_if.slave bus
);

  localparam int SC_W = IN_W + OUT_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  // Settle counter is loaded with SETTLE-1 so that the response is sampled
  // exactly SETTLE+1 edges after the apply edge.
  localparam logic [7:0]       CNT_INIT = 8'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [SC_W-1:0]  r_sc;
  logic [IN_W-1:0]  r_stim;
  logic [OUT_W-1:0] r_exp;
  logic [OUT_W-1:0] r_cap;
  logic [7:0]       r_cnt;
  logic [1:0]       r_state;
  logic             r_fail;
  logic             r_done;
  logic [ERR_W-1:0] r_err;

  logic w_idle;
  logic w_shift;
  logic w_accept;
  logic w_capture;
  logic w_mismatch;

  // Saturating increment of the mismatch counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  // Scan and apply are only honoured in IDLE; scan takes priority over apply.
  assign w_idle     = (r_state == S_IDLE);
  assign w_shift    = w_idle && bus.scan_en;
  assign w_accept   = w_idle && bus.apply && !bus.scan_en;
  assign w_capture  = (r_state == S_CAPTURE);
  assign w_mismatch = (bus.resp_in != r_exp);

  // Scan chain shift and capture-register shift/load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc  <= '0;
      r_cap <= '0;
    end else if (w_shift) begin
      r_sc  <= {r_sc[SC_W-2:0], bus.scan_in};
      r_cap <= r_cap << 1;
    end else if (w_capture) begin
      r_cap <= bus.resp_in;
    end
  end

  // Stimulus and expected words are latched only when a sequence starts,
  // so scanning never disturbs the DUT inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stim <= '0;
      r_exp  <= '0;
    end else if (w_accept) begin
      r_stim <= r_sc[SC_W-1 -: IN_W];
      r_exp  <= r_sc[OUT_W-1:0];
    end
  end

  // Sequence FSM: IDLE -> SETTLE (counted) -> CAPTURE (one cycle) -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_INIT;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Compare result, done pulse and error counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail <= 1'b0;
      r_done <= 1'b0;
      r_err  <= '0;
    end else begin
      r_done <= w_capture;
      if (w_capture) begin
        r_fail <= w_mismatch;
      end
      if (bus.clr_err) begin
        r_err <= '0;
      end else if (w_capture && w_mismatch) begin
        r_err <= sat_inc(r_err);
      end
    end
  end

  assign bus.scan_out = r_cap[OUT_W-1];
  assign bus.stim_out = r_stim;
  assign bus.busy     = !w_idle;
  assign bus.done     = r_done;
  assign bus.fail     = r_fail;
  assign bus.err_cnt  = r_err;

endmodule

// File: tb/tb_io_scan_harness.sv
// Bench for io_scan_harness: directed scenarios with literal expectations
// plus a randomized phase, all compared against a transaction-level model.
module tb_io_scan_harness;

  localparam int IN_W   = 8;
  localparam int OUT_W  = 8;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_scan_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ERR_W(8)) bus_a ();
  io_scan_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ERR_W(2)) bus_b ();

  assign bus_b.scan_en = bus_a.scan_en;
  assign bus_b.scan_in = bus_a.scan_in;
  assign bus_b.apply   = bus_a.apply;
  assign bus_b.clr_err = bus_a.clr_err;
  assign bus_b.resp_in = bus_a.resp_in;

  io_scan_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .ERR_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  io_scan_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .ERR_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the scan word, the latched stimulus/expected pair and the edge
  // number on which the pending capture will happen (-1 when none).
  logic [15:0] m_sc;
  logic [7:0]  m_stim, m_exp, m_cap;
  logic        m_fail, m_done;
  int          m_err8, m_err2;
  int          m_edge, m_cap_edge;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sc = '0; m_stim = '0; m_exp = '0; m_cap = '0;
      m_fail = 1'b0; m_done = 1'b0; m_err8 = 0; m_err2 = 0;
      m_edge = 0; m_cap_edge = -1;
    end else begin
      m_edge++;
      m_done = 1'b0;
      if (m_cap_edge >= 0) begin
        if (m_edge == m_cap_edge) begin
          m_cap  = bus_a.resp_in;
          m_fail = (bus_a.resp_in != m_exp);
          if (m_fail) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3)   m_err2++;
          end
          m_done     = 1'b1;
          m_cap_edge = -1;
        end
      end else if (bus_a.scan_en) begin
        m_sc  = {m_sc[14:0], bus_a.scan_in};
        m_cap = {m_cap[6:0], 1'b0};
      end else if (bus_a.apply) begin
        m_stim     = m_sc[15:8];
        m_exp      = m_sc[7:0];
        m_cap_edge = m_edge + SETTLE + 1;
      end
      if (bus_a.clr_err) begin
        m_err8 = 0;
        m_err2 = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("stim_out", bus_a.stim_out, m_stim);
      chk("busy",     bus_a.busy,     (m_cap_edge >= 0));
      chk("done",     bus_a.done,     m_done);
      chk("fail",     bus_a.fail,     m_fail);
      chk("err_cnt",  bus_a.err_cnt,  m_err8);
      chk("scan_out", bus_a.scan_out, m_cap[7]);
      chk("sat_busy", bus_b.busy,     (m_cap_edge >= 0));
      chk("sat_done", bus_b.done,     m_done);
      chk("sat_err",  bus_b.err_cnt,  m_err2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic shift_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus_a.scan_en = 1'b1;
      bus_a.scan_in = w[i];
      cyc();
    end
    bus_a.scan_en = 1'b0;
  endtask

  task automatic start_apply();
    bus_a.apply = 1'b1;
    cyc();
    bus_a.apply = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!bus_a.done && k < 20) begin
      cyc();
      k++;
    end
    chk(nm, bus_a.done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bits_exp;
    int         sat_exp [4];
    sat_exp = '{1, 2, 3, 3};

    bus_a.scan_en = 1'b0;
    bus_a.scan_in = 1'b0;
    bus_a.apply   = 1'b0;
    bus_a.clr_err = 1'b0;
    bus_a.resp_in = '0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_stim",  bus_a.stim_out, 8'h00);
    chk("rst_busy",  bus_a.busy,     1'b0);
    chk("rst_done",  bus_a.done,     1'b0);
    chk("rst_fail",  bus_a.fail,     1'b0);
    chk("rst_err",   bus_a.err_cnt,  8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Basic pass sequence
    bus_a.resp_in = 8'h5A;
    shift_word(16'hA55A, 16);
    start_apply();
    chk("pass_stim", bus_a.stim_out, 8'hA5);
    chk("pass_busy", bus_a.busy, 1'b1);
    cyc();
    cyc();
    chk("pass_done_early", bus_a.done, 1'b0);
    cyc();
    chk("pass_done", bus_a.done, 1'b1);
    chk("pass_fail", bus_a.fail, 1'b0);
    chk("pass_err",  bus_a.err_cnt, 8'h00);
    cyc();
    chk("pass_done_width", bus_a.done, 1'b0);
    chk("pass_busy_end",   bus_a.busy, 1'b0);

    // Mismatch and serial readout of the captured word
    bus_a.resp_in = 8'h5B;
    shift_word(16'hA55A, 16);
    start_apply();
    repeat (3) cyc();
    chk("mm_done", bus_a.done, 1'b1);
    chk("mm_fail", bus_a.fail, 1'b1);
    chk("mm_err",  bus_a.err_cnt, 8'h01);
    cyc();
    bits_exp = 8'b0101_1011;
    for (int i = 7; i >= 0; i--) begin
      chk("scan_out_bit", bus_a.scan_out, bits_exp[i]);
      bus_a.scan_en = 1'b1;
      bus_a.scan_in = 1'b0;
      cyc();
    end
    bus_a.scan_en = 1'b0;

    // Inputs ignored while busy; apply+scan_en in IDLE shifts once
    bus_a.resp_in = 8'h5A;
    shift_word(16'hA55A, 16);
    start_apply();
    bus_a.scan_en = 1'b1;
    bus_a.scan_in = 1'b1;
    bus_a.apply   = 1'b1;
    cyc();
    cyc();
    bus_a.scan_en = 1'b0;
    bus_a.apply   = 1'b0;
    cyc();
    chk("busy_ign_done", bus_a.done, 1'b1);
    cyc();
    bus_a.scan_en = 1'b1;
    bus_a.scan_in = 1'b1;
    bus_a.apply   = 1'b1;
    cyc();
    bus_a.scan_en = 1'b0;
    bus_a.apply   = 1'b0;
    chk("combo_no_start", bus_a.busy, 1'b0);
    start_apply();
    chk("combo_one_shift", bus_a.stim_out, 8'h4A);
    wait_done("combo_done");
    chk("combo_err", bus_a.err_cnt, 8'h02);
    cyc();

    // Saturation of the 2-bit counter
    bus_a.clr_err = 1'b1;
    cyc();
    bus_a.clr_err = 1'b0;
    chk("clr_err", bus_b.err_cnt, 2'd0);
    bus_a.resp_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      start_apply();
      wait_done("sat_done_wait");
      chk("sat_cnt", bus_b.err_cnt, sat_exp[i]);
      cyc();
    end

    // Clear coincident with a mismatching capture
    start_apply();
    cyc();
    cyc();
    bus_a.clr_err = 1'b1;
    cyc();
    bus_a.clr_err = 1'b0;
    chk("clr_cap_done", bus_a.done, 1'b1);
    chk("clr_cap_err",  bus_a.err_cnt, 8'h00);
    chk("clr_cap_fail", bus_a.fail, 1'b1);
    cyc();

    // Reset during SETTLE aborts the sequence
    bus_a.resp_in = 8'h5A;
    shift_word(16'hA55A, 16);
    start_apply();
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("abort_stim", bus_a.stim_out, 8'h00);
    chk("abort_busy", bus_a.busy, 1'b0);
    chk("abort_err",  bus_a.err_cnt, 8'h00);
    cyc();
    rst = 1'b0;
    cyc();
    chk("abort_no_done", bus_a.done, 1'b0);
    shift_word(16'hA55A, 16);
    start_apply();
    chk("post_rst_stim", bus_a.stim_out, 8'hA5);
    cyc();
    cyc();
    cyc();
    chk("post_rst_done", bus_a.done, 1'b1);
    chk("post_rst_fail", bus_a.fail, 1'b0);
    cyc();

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      bus_a.scan_en = ($urandom_range(0, 2) == 0);
      bus_a.scan_in = 1'($urandom);
      bus_a.apply   = ($urandom_range(0, 3) == 0);
      bus_a.clr_err = ($urandom_range(0, 15) == 0);
      bus_a.resp_in = ($urandom_range(0, 2) == 0) ? m_exp : 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end
    bus_a.scan_en = 1'b0;
    bus_a.apply   = 1'b0;
    bus_a.clr_err = 1'b0;
    repeat (6) cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
